// File: rtl/ttt_bot_player.sv
// Tic-tac-toe bot: one line per cycle scanning for a win, then a block, then a fixed-preference fallback.
// Optional feature: define TTT_BOT_BLOCK_EN to include the opponent-blocking scan (SCAN_BLOCK).
module ttt_bot_player (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [8:0] board_x,
  input  logic [8:0] board_o,
  input  logic       bot_is_o,
  output logic       busy,
  output logic       done,
  output logic [8:0] move,
  output logic       no_move
);

  typedef enum logic [2:0] {IDLE, SCAN_WIN, SCAN_BLOCK, FALLBACK, DONE} state_t;

  state_t     state;
  logic [8:0] snap_x, snap_o;
  logic       snap_is_o;
  logic [2:0] line_idx;

  logic [8:0] x_only, o_only, empty;
  logic [8:0] bot_m, scan_m, cur_line, gap;
  logic [8:0] fb_pick;
  logic       hit;

  function automatic logic [8:0] line_cells(input logic [2:0] idx);
    case (idx)
      3'd0:    line_cells = 9'h007;
      3'd1:    line_cells = 9'h038;
      3'd2:    line_cells = 9'h1C0;
      3'd3:    line_cells = 9'h049;
      3'd4:    line_cells = 9'h092;
      3'd5:    line_cells = 9'h124;
      3'd6:    line_cells = 9'h111;
      default: line_cells = 9'h054;
    endcase
  endfunction

  // A cell claimed by both snapshots is occupied but owned by neither side.
  assign x_only   = snap_x & ~snap_o;
  assign o_only   = snap_o & ~snap_x;
  assign empty    = ~(snap_x | snap_o);
  assign bot_m    = snap_is_o ? o_only : x_only;
  assign cur_line = line_cells(line_idx);
  assign gap      = cur_line & empty;

`ifdef TTT_BOT_BLOCK_EN
  logic [8:0] opp_m;
  assign opp_m  = snap_is_o ? x_only : o_only;
  assign scan_m = (state == SCAN_BLOCK) ? opp_m : bot_m;
`else
  assign scan_m = bot_m;
`endif

  // Two marks on a three-cell line plus any empty cell leaves exactly one gap.
  assign hit = ($countones(cur_line & scan_m) == 2) && (gap != 9'h000);

  always_comb begin
    fb_pick = 9'h000;
    if      (empty[4]) fb_pick = 9'h010;
    else if (empty[0]) fb_pick = 9'h001;
    else if (empty[2]) fb_pick = 9'h004;
    else if (empty[6]) fb_pick = 9'h040;
    else if (empty[8]) fb_pick = 9'h100;
    else if (empty[1]) fb_pick = 9'h002;
    else if (empty[3]) fb_pick = 9'h008;
    else if (empty[5]) fb_pick = 9'h020;
    else if (empty[7]) fb_pick = 9'h080;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      move      <= 9'h000;
      no_move   <= 1'b0;
      snap_x    <= 9'h000;
      snap_o    <= 9'h000;
      snap_is_o <= 1'b0;
      line_idx  <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            snap_x    <= board_x;
            snap_o    <= board_o;
            snap_is_o <= bot_is_o;
            line_idx  <= 3'd0;
            move      <= 9'h000;
            no_move   <= 1'b0;
            busy      <= 1'b1;
            state     <= SCAN_WIN;
          end
        end
        SCAN_WIN: begin
          if (hit) begin
            move  <= gap;
            done  <= 1'b1;
            state <= DONE;
          end else if (line_idx == 3'd7) begin
            line_idx <= 3'd0;
`ifdef TTT_BOT_BLOCK_EN
            state    <= SCAN_BLOCK;
`else
            state    <= FALLBACK;
`endif
          end else begin
            line_idx <= line_idx + 3'd1;
          end
        end
`ifdef TTT_BOT_BLOCK_EN
        SCAN_BLOCK: begin
          if (hit) begin
            move  <= gap;
            done  <= 1'b1;
            state <= DONE;
          end else if (line_idx == 3'd7) begin
            line_idx <= 3'd0;
            state    <= FALLBACK;
          end else begin
            line_idx <= line_idx + 3'd1;
          end
        end
`endif
        FALLBACK: begin
          move    <= fb_pick;
          no_move <= (fb_pick == 9'h000);
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
